// File: rtl/game_pkg.sv
// Shared game types for the light-cycle controllers: tiles, directions, modes
// and the per-player helper functions.
package game_pkg;

   localparam int MAP_WIDTH   = 16;
   localparam int MAP_HEIGHT  = 12;
   localparam int MAX_PLAYERS = 4;

   typedef enum logic [2:0] {EMPTY, FRAME, PLAYER1, PLAYER2, PLAYER3, PLAYER4} tile;
   typedef enum logic [2:0] {WAIT, UP, DOWN, LEFT, RIGHT} directions;
   typedef enum logic [1:0] {START, PLAY, PAUSE, FINISHED} game_mode;
   typedef enum logic [1:0] {IDLE, RUN, OVER} ctrl_state_t;

   function automatic tile player_tile(input int k);
      return tile'(3'(int'(PLAYER1) + k));
   endfunction

   function automatic int start_x(input int k, input int n, input int w);
      return (k + 1) * w / (n + 1);
   endfunction

endpackage

// File: rtl/multi_player_control_if.sv
// Bundle between the game-mode/renderer side (master) and the movement
// controller (slave).
interface multi_player_control_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int MAP_W       = game_pkg::MAP_WIDTH,
   parameter int MAP_H       = game_pkg::MAP_HEIGHT
);
   import game_pkg::*;

   localparam int WW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

   directions              direction [NUM_PLAYERS];
   game_mode               mode;
   tile                    map [MAP_W][MAP_H];
   logic [NUM_PLAYERS-1:0] alive;
   logic [NUM_PLAYERS-1:0] collision;
   logic                   step_done;
   logic                   game_over;
   logic                   winner_valid;
   logic [WW-1:0]          winner;

   modport master (
      output direction, mode,
      input  map, alive, collision, step_done, game_over, winner_valid, winner
   );

   modport slave (
      input  direction, mode,
      output map, alive, collision, step_done, game_over, winner_valid, winner
   );

endinterface

// File: rtl/move_resolver.sv
// Combinational step resolution: per-player target cell and crash flag.
// MAP_WRAP_EN makes targets wrap around the map edges instead of hitting a frame.
module move_resolver
   import game_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int MAP_W       = MAP_WIDTH,
   parameter int MAP_H       = MAP_HEIGHT,
   localparam int XW         = $clog2(MAP_W),
   localparam int YW         = $clog2(MAP_H)
) (
   input  logic [XW-1:0]          pos_x [NUM_PLAYERS],
   input  logic [YW-1:0]          pos_y [NUM_PLAYERS],
   input  directions              dir   [NUM_PLAYERS],
   input  logic [NUM_PLAYERS-1:0] alive,
   input  tile                    map   [MAP_W][MAP_H],
   output logic [XW-1:0]          tgt_x [NUM_PLAYERS],
   output logic [YW-1:0]          tgt_y [NUM_PLAYERS],
   output logic [NUM_PLAYERS-1:0] crash
);

   logic [NUM_PLAYERS-1:0] mover;
   tile                    tgt_tile [NUM_PLAYERS];

   function automatic logic [XW-1:0] step_x(input logic [XW-1:0] x, input directions d);
      logic [XW-1:0] r;
      r = x;
`ifdef MAP_WRAP_EN
      if (d == LEFT)  r = (x == '0) ? XW'(MAP_W - 1) : x - XW'(1);
      if (d == RIGHT) r = (x == XW'(MAP_W - 1)) ? '0 : x + XW'(1);
`else
      if (d == LEFT)  r = x - XW'(1);
      if (d == RIGHT) r = x + XW'(1);
`endif
      return r;
   endfunction

   function automatic logic [YW-1:0] step_y(input logic [YW-1:0] y, input directions d);
      logic [YW-1:0] r;
      r = y;
`ifdef MAP_WRAP_EN
      if (d == UP)   r = (y == '0) ? YW'(MAP_H - 1) : y - YW'(1);
      if (d == DOWN) r = (y == YW'(MAP_H - 1)) ? '0 : y + YW'(1);
`else
      if (d == UP)   r = y - YW'(1);
      if (d == DOWN) r = y + YW'(1);
`endif
      return r;
   endfunction

   function automatic logic in_map(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return ({1'b0, x} < (XW+1)'(MAP_W)) && ({1'b0, y} < (YW+1)'(MAP_H));
   endfunction

   // Anything off the map reads as a wall so a stray target can never be written.
   for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_tgt
      assign mover[gi]    = alive[gi] && (dir[gi] != WAIT);
      assign tgt_x[gi]    = step_x(pos_x[gi], dir[gi]);
      assign tgt_y[gi]    = step_y(pos_y[gi], dir[gi]);
      assign tgt_tile[gi] = in_map(tgt_x[gi], tgt_y[gi]) ? map[tgt_x[gi]][tgt_y[gi]] : FRAME;
   end

   always_comb begin
      crash = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (mover[i]) begin
            if (tgt_tile[i] != EMPTY) crash[i] = 1'b1;
            for (int j = 0; j < NUM_PLAYERS; j++) begin
               if (j != i && mover[j]) begin
                  if (tgt_x[i] == tgt_x[j] && tgt_y[i] == tgt_y[j]) crash[i] = 1'b1;
                  if (tgt_x[i] == pos_x[j] && tgt_y[i] == pos_y[j] &&
                      tgt_x[j] == pos_x[i] && tgt_y[j] == pos_y[i]) crash[i] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/multi_player_control.sv
// Multi-player light-cycle controller: step timing FSM, map and player state.
// MAP_WRAP_EN removes the frame border so players wrap around the map edges.
module multi_player_control
   import game_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int MAP_W       = MAP_WIDTH,
   parameter int MAP_H       = MAP_HEIGHT,
   parameter int STEP_CYCLES = 4
) (
   input logic                   clk,
   input logic                   rst,
   multi_player_control_if.slave bus
);

   localparam int XW = $clog2(MAP_W);
   localparam int YW = $clog2(MAP_H);
   localparam int WW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int CW = $clog2(STEP_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

   ctrl_state_t            state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   tile                    map_q [MAP_W][MAP_H];
   tile                    map_d [MAP_W][MAP_H];
   tile                    init_map [MAP_W][MAP_H];
   logic [XW-1:0]          pos_x_q [NUM_PLAYERS], pos_x_d [NUM_PLAYERS], init_x [NUM_PLAYERS];
   logic [YW-1:0]          pos_y_q [NUM_PLAYERS], pos_y_d [NUM_PLAYERS], init_y [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] alive_q, alive_d, collision_q, collision_d;
   logic                   step_done_q, step_done_d, game_over_q, game_over_d;
   logic                   winner_valid_q, winner_valid_d;
   logic [WW-1:0]          winner_q, winner_d;

   logic [XW-1:0]          tgt_x [NUM_PLAYERS];
   logic [YW-1:0]          tgt_y [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] crash, alive_post;
   logic [2:0]             n_alive;
   logic [WW-1:0]          survivor;
   logic                   commit, last_standing;

   function automatic tile init_tile(input int x, input int y);
      tile t;
      t = EMPTY;
`ifndef MAP_WRAP_EN
      if (x == 0 || y == 0 || x == MAP_W - 1 || y == MAP_H - 1) t = FRAME;
`endif
      for (int k = 0; k < NUM_PLAYERS; k++)
         if (x == start_x(k, NUM_PLAYERS, MAP_W) && y == MAP_H / 2) t = player_tile(k);
      return t;
   endfunction

   for (genvar gi = 0; gi < MAP_W; gi++) begin : g_col
      for (genvar gj = 0; gj < MAP_H; gj++) begin : g_row
         assign init_map[gi][gj] = init_tile(gi, gj);
      end
   end

   for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_start
      assign init_x[gi] = XW'(start_x(gi, NUM_PLAYERS, MAP_W));
      assign init_y[gi] = YW'(MAP_H / 2);
   end

   move_resolver #(.NUM_PLAYERS(NUM_PLAYERS), .MAP_W(MAP_W), .MAP_H(MAP_H)) u_resolver (
      .pos_x(pos_x_q), .pos_y(pos_y_q), .dir(bus.direction), .alive(alive_q),
      .map(map_q), .tgt_x(tgt_x), .tgt_y(tgt_y), .crash(crash)
   );

   assign commit = (state_q == RUN) && (bus.mode == PLAY) && (cnt_q == CNT_LAST);

   always_comb begin
      alive_post = alive_q & ~crash;
      n_alive    = '0;
      survivor   = '0;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
         if (alive_post[k]) begin
            n_alive  = n_alive + 3'd1;
            survivor = WW'(k);
         end
      end
   end

   assign last_standing = (n_alive <= 3'd1);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.mode == START) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bus.mode == PLAY) state_d = RUN;
            RUN:     if (commit && last_standing) state_d = OVER;
            OVER:    state_d = OVER;
            default: state_d = IDLE;
         endcase
      end
   end

   // The whole step lands on one edge, so no partially updated map is ever visible.
   always_comb begin
      cnt_d          = cnt_q;
      map_d          = map_q;
      pos_x_d        = pos_x_q;
      pos_y_d        = pos_y_q;
      alive_d        = alive_q;
      collision_d    = collision_q;
      step_done_d    = 1'b0;
      game_over_d    = game_over_q;
      winner_valid_d = winner_valid_q;
      winner_d       = winner_q;
      if (bus.mode == START) begin
         cnt_d          = '0;
         map_d          = init_map;
         pos_x_d        = init_x;
         pos_y_d        = init_y;
         alive_d        = '1;
         collision_d    = '0;
         game_over_d    = 1'b0;
         winner_valid_d = 1'b0;
         winner_d       = '0;
      end else if (state_q == RUN && bus.mode == PLAY) begin
         cnt_d = commit ? '0 : cnt_q + CW'(1);
         if (commit) begin
            step_done_d = 1'b1;
            for (int k = 0; k < NUM_PLAYERS; k++) begin
               if (crash[k]) begin
                  alive_d[k]     = 1'b0;
                  collision_d[k] = 1'b1;
               end else if (alive_q[k] && bus.direction[k] != WAIT) begin
                  map_d[tgt_x[k]][tgt_y[k]] = player_tile(k);
                  pos_x_d[k] = tgt_x[k];
                  pos_y_d[k] = tgt_y[k];
               end
            end
            if (last_standing) begin
               game_over_d    = 1'b1;
               winner_valid_d = (n_alive == 3'd1);
               winner_d       = survivor;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q          <= '0;
         map_q          <= init_map;
         pos_x_q        <= init_x;
         pos_y_q        <= init_y;
         alive_q        <= '1;
         collision_q    <= '0;
         step_done_q    <= 1'b0;
         game_over_q    <= 1'b0;
         winner_valid_q <= 1'b0;
         winner_q       <= '0;
      end else begin
         cnt_q          <= cnt_d;
         map_q          <= map_d;
         pos_x_q        <= pos_x_d;
         pos_y_q        <= pos_y_d;
         alive_q        <= alive_d;
         collision_q    <= collision_d;
         step_done_q    <= step_done_d;
         game_over_q    <= game_over_d;
         winner_valid_q <= winner_valid_d;
         winner_q       <= winner_d;
      end
   end

   always_comb begin
      bus.map          = map_q;
      bus.alive        = alive_q;
      bus.collision    = collision_q;
      bus.step_done    = step_done_q;
      bus.game_over    = game_over_q;
      bus.winner_valid = winner_valid_q;
      bus.winner       = winner_q;
   end

endmodule
